forward_hazard_unit: RTL and testbench

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

---
 rtl/forward_hazard_unit_pkg.sv | 55 +++++
 rtl/fwd_shadow_reg.sv | 31 +++
 rtl/forward_hazard_unit.sv | 104 ++++++++++
 tb/tb_forward_hazard_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : forward_hazard_unit_pkg
//  Purpose  : Shared types, encodings and the forward-select helper for the
//             forwarding / hazard-detection unit.
//  Revision : 1.0 - initial release
// ============================================================================
package forward_hazard_unit_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int STALL_CNT_W = 16;

  // Operand mux select for the EX-stage 3:1 muxes
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // result_src encodings; 2'b11 is reserved and behaves like ALU
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // EX shadow carries sources too, MEM/WB only need the writer identity
  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 is_load;
  } ex_fields_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } wr_fields_t;

  // Younger producer (MEM) has priority; x0 is hard-wired and never forwarded
  function automatic fwd_sel_e fwd_select(
    input logic [REG_IDX_W-1:0] rs,
    input logic [REG_IDX_W-1:0] rd_m,
    input logic                 rw_m,
    input logic [REG_IDX_W-1:0] rd_w,
    input logic                 rw_w
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (rs != '0 && rs == rd_m && rw_m)      sel = FWD_MEM;
    else if (rs != '0 && rs == rd_w && rw_w) sel = FWD_WB;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_shadow_reg
//  Purpose  : One stage of the control-state shadow pipeline. The field set
//             is packed by the parent; WIDTH sizes it. Async reset, sync clear
//             (used to inject a bubble).
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_shadow_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Stage register: bubble on clr, otherwise take the upstream stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_q <= '0;
    else if (clr) r_q <= '0;
    else          r_q <= d;
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : forward_hazard_unit
//  Purpose  : Operand forwarding selects and load-use / control hazard
//             stall & flush generation for a 5-stage pipeline, driven from a
//             private shadow copy of the EX/MEM/WB control state.
//  Revision : 1.0 - initial release
// ============================================================================
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_IDX_W-1:0]   rs1_d,
  input  logic [REG_IDX_W-1:0]   rs2_d,
  input  logic [REG_IDX_W-1:0]   rd_d,
  input  logic                   reg_write_d,
  input  logic [1:0]             result_src_d,
  input  logic                   pc_src_e,
  output logic [1:0]             forward_a_e,
  output logic [1:0]             forward_b_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int c_EX_W = $bits(ex_fields_t);
  localparam int c_WR_W = $bits(wr_fields_t);

  ex_fields_t w_ex_d;
  ex_fields_t w_ex_q;
  wr_fields_t w_mem_d;
  wr_fields_t w_mem_q;
  wr_fields_t w_wb_q;
  logic       w_lw_stall;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Pack the decode-stage fields for the EX shadow
  always_comb begin
    w_ex_d           = '0;
    w_ex_d.rs1       = rs1_d;
    w_ex_d.rs2       = rs2_d;
    w_ex_d.rd        = rd_d;
    w_ex_d.reg_write = reg_write_d;
    w_ex_d.is_load   = (result_src_d == RES_LOAD);
    w_mem_d          = '0;
    w_mem_d.rd       = w_ex_q.rd;
    w_mem_d.reg_write = w_ex_q.reg_write;
  end

  fwd_shadow_reg #(.WIDTH(c_EX_W)) u_ex (
    .clk (clk),
    .rst (reset),
    .clr (flush_e),
    .d   (w_ex_d),
    .q   (w_ex_q)
  );

  fwd_shadow_reg #(.WIDTH(c_WR_W)) u_mem (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .d   (w_mem_d),
    .q   (w_mem_q)
  );

  fwd_shadow_reg #(.WIDTH(c_WR_W)) u_wb (
    .clk (clk),
    .rst (reset),
    .clr (1'b0),
    .d   (w_mem_q),
    .q   (w_wb_q)
  );

  // Hazard and forward decisions, purely combinational from shadow + decode
  always_comb begin
    forward_a_e = fwd_select(w_ex_q.rs1, w_mem_q.rd, w_mem_q.reg_write,
                             w_wb_q.rd, w_wb_q.reg_write);
    forward_b_e = fwd_select(w_ex_q.rs2, w_mem_q.rd, w_mem_q.reg_write,
                             w_wb_q.rd, w_wb_q.reg_write);
    // A taken branch discards the dependent instruction, so it wins over a stall
    w_lw_stall  = w_ex_q.is_load && (w_ex_q.rd != '0) &&
                  ((w_ex_q.rd == rs1_d) || (w_ex_q.rd == rs2_d)) && !pc_src_e;
    stall_f     = w_lw_stall;
    stall_d     = w_lw_stall;
    // flush_d is masked during reset; flush_e keeps following the branch
    flush_d     = pc_src_e && !reset;
    flush_e     = w_lw_stall || pc_src_e;
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (stall_d && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_forward_hazard_unit
//  Purpose  : Directed self-checking bench for forward_hazard_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d;
  logic [1:0]  result_src_d;
  logic        pc_src_e;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  forward_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_d         (rd_d),
    .reg_write_d  (reg_write_d),
    .result_src_d (result_src_d),
    .pc_src_e     (pc_src_e),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a decode-stage instruction and let combinational outputs settle
  task automatic setd(input int rs1, input int rs2, input int rd,
                      input bit rw, input int src);
    rs1_d        = 5'(rs1);
    rs2_d        = 5'(rs2);
    rd_d         = 5'(rd);
    reg_write_d  = rw;
    result_src_d = 2'(src);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    setd(0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    reset    = 1'b1;
    pc_src_e = 1'b0;
    setd(0, 0, 0, 0, 0);
    #12;
    check("rst_fa", forward_a_e, 0);
    check("rst_fb", forward_b_e, 0);
    check("rst_stall", {stall_f, stall_d}, 0);
    check("rst_flush", {flush_d, flush_e}, 0);
    check("rst_cnt", stall_cnt, 0);
    pc_src_e = 1'b1; #1;
    check("rst_pc_flush_d", flush_d, 0);
    check("rst_pc_flush_e", flush_e, 1);
    pc_src_e = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick();

    // ALU RAW distance 1: add x5,x1,x2 ; sub x6,x5,x1
    setd(1, 2, 5, 1, 0); tick();
    setd(5, 1, 6, 1, 0);
    check("raw1_nostall", stall_d, 0);
    tick();
    setd(0, 0, 0, 0, 0);
    check("raw1_fa", forward_a_e, 2);
    check("raw1_fb", forward_b_e, 0);
    check("raw1_stall", {stall_f, stall_d, flush_e}, 0);
    drain();

    // Distance-2 RAW on x5
    setd(1, 2, 5, 1, 0); tick();
    setd(0, 0, 0, 0, 0); tick();
    setd(5, 3, 9, 1, 0); tick();
    setd(0, 0, 0, 0, 0);
    check("raw2_fa", forward_a_e, 1);
    check("raw2_fb", forward_b_e, 0);
    drain();

    // x5 written in MEM and WB: MEM wins, both operands
    setd(1, 2, 5, 1, 0); tick();
    setd(9, 9, 5, 1, 0); tick();
    setd(5, 5, 10, 1, 0); tick();
    setd(0, 0, 0, 0, 0);
    check("both_fa", forward_a_e, 2);
    check("both_fb", forward_b_e, 2);
    drain();

    // Load-use: lw x7 ; add x8,x7,x7
    setd(2, 0, 7, 1, 1); tick();
    setd(7, 7, 8, 1, 0);
    check("lu_stall_f", stall_f, 1);
    check("lu_stall_d", stall_d, 1);
    check("lu_flush_e", flush_e, 1);
    check("lu_flush_d", flush_d, 0);
    check("lu_cnt0", stall_cnt, 0);
    tick();
    check("lu_cnt1", stall_cnt, 1);
    check("lu_once", stall_d, 0);
    check("lu_bubble_fa", forward_a_e, 0);
    tick();
    setd(0, 0, 0, 0, 0);
    check("lu_fa_wb", forward_a_e, 1);
    check("lu_fb_wb", forward_b_e, 1);
    drain();

    // Load to x0 then read x0: no stall, no forward
    setd(2, 0, 0, 1, 1); tick();
    setd(0, 0, 3, 1, 0);
    check("x0_nostall", stall_d, 0);
    tick();
    setd(0, 0, 0, 0, 0);
    check("x0_fa", forward_a_e, 0);
    check("x0_fb", forward_b_e, 0);
    drain();

    // Branch taken coincident with load-use: branch wins
    setd(2, 0, 7, 1, 1); tick();
    setd(7, 7, 8, 1, 0);
    pc_src_e = 1'b1; #1;
    check("br_flush", {flush_d, flush_e}, 3);
    check("br_stall", {stall_f, stall_d}, 0);
    tick();
    pc_src_e = 1'b0;
    setd(0, 0, 0, 0, 0);
    check("br_bubble_fa", forward_a_e, 0);
    check("br_bubble_fb", forward_b_e, 0);
    check("br_cnt", stall_cnt, 1);
    drain();

    // Saturation: preload FFFE, then three stalls
    force dut.r_stall_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    #1;
    check("sat_preload", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      setd(2, 0, 7, 1, 1); tick();
      setd(7, 7, 8, 1, 0);
      check("sat_stall", stall_d, 1);
      tick();
      check("sat_cnt", stall_cnt, 16'hFFFF);
    end
    drain();

    // Asynchronous reset in the middle of a stall cycle
    setd(2, 0, 7, 1, 1); tick();
    setd(7, 7, 8, 1, 0);
    check("ar_pre_stall", stall_d, 1);
    #2;
    reset = 1'b1; #1;
    check("ar_cnt", stall_cnt, 0);
    check("ar_stall", {stall_f, stall_d}, 0);
    check("ar_flush", {flush_d, flush_e}, 0);
    check("ar_fwd", {forward_a_e, forward_b_e}, 0);
    #1;
    reset = 1'b0; #1;
    check("ar_no_persist", stall_d, 0);
    tick();
    check("ar_cnt_after", stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
